// File: rtl/io_poll_master.sv
// Polled I/O master: waits for input ready, reads two input bytes, writes their sum to the output port.
// Optional macro IO_POLL_TIMEOUT_EN adds a per-poll-state timeout into an ERR state.
module io_poll_master #(
    parameter int unsigned POLL_LIMIT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        pRead,
    output logic        pWrite,
    output logic [1:0]  addr,
    output logic [11:0] pWriteData,
    input  logic [31:0] pReadData,
    output logic [11:0] result,
    output logic        done,
    output logic [7:0]  txn_count,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL_IN,
        S_RD_LO,
        S_RD_HI,
        S_WR,
        S_POLL_OUT,
        S_DONE
`ifdef IO_POLL_TIMEOUT_EN
        ,
        S_ERR
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [11:0] result_q, result_d;
    logic [7:0]  txn_q, txn_d;
    logic [8:0]  sum;

    assign sum = {1'b0, lo_q} + {1'b0, hi_q};

`ifdef IO_POLL_TIMEOUT_EN
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        poll_expired;

    assign poll_expired = (poll_cnt_q == 16'(POLL_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
        end
    end
`else
    logic [15:0] unused_limit;
    assign unused_limit = 16'(POLL_LIMIT);
`endif

    logic [23:0] unused_rdata;
    assign unused_rdata = pReadData[31:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            result_q <= '0;
            txn_q    <= '0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            result_q <= result_d;
            txn_q    <= txn_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        result_d = result_q;
        txn_d    = txn_q;
`ifdef IO_POLL_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_POLL_IN;
`ifdef IO_POLL_TIMEOUT_EN
                    poll_cnt_d = '0;
`endif
                end
            end
            S_POLL_IN: begin
                if (pReadData[1]) begin
                    state_d = S_RD_LO;
`ifdef IO_POLL_TIMEOUT_EN
                end else if (poll_expired) begin
                    state_d = S_ERR;
                end else begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
`endif
                end
            end
            S_RD_LO: begin
                lo_d    = pReadData[7:0];
                state_d = S_RD_HI;
            end
            S_RD_HI: begin
                hi_d    = pReadData[7:0];
                state_d = S_WR;
            end
            S_WR: begin
                result_d = {3'b000, sum};
                state_d  = S_POLL_OUT;
`ifdef IO_POLL_TIMEOUT_EN
                poll_cnt_d = '0;
`endif
            end
            S_POLL_OUT: begin
                if (pReadData[0]) begin
                    state_d = S_DONE;
`ifdef IO_POLL_TIMEOUT_EN
                end else if (poll_expired) begin
                    state_d = S_ERR;
                end else begin
                    poll_cnt_d = poll_cnt_q + 16'd1;
`endif
                end
            end
            S_DONE: begin
                txn_d = txn_q + 8'd1;
                if (run) begin
                    state_d = S_POLL_IN;
`ifdef IO_POLL_TIMEOUT_EN
                    poll_cnt_d = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef IO_POLL_TIMEOUT_EN
            S_ERR: begin
                if (!run) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Port strobes and status flags are pure decodes of the state register.
    always_comb begin
        pRead      = 1'b0;
        pWrite     = 1'b0;
        addr       = 2'b00;
        pWriteData = '0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_POLL_IN:  pRead = 1'b1;
            S_RD_LO: begin
                pRead = 1'b1;
                addr  = 2'b10;
            end
            S_RD_HI: begin
                pRead = 1'b1;
                addr  = 2'b11;
            end
            S_WR: begin
                pWrite     = 1'b1;
                addr       = 2'b01;
                pWriteData = {3'b000, sum};
            end
            S_POLL_OUT: pRead = 1'b1;
            S_DONE:     done  = 1'b1;
`ifdef IO_POLL_TIMEOUT_EN
            S_ERR:      err   = 1'b1;
`endif
            default: ;
        endcase
    end

    assign result    = result_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_io_poll_master.sv
// Directed self-checking bench for io_poll_master with a behavioural status/input/output port.
// Exercises the IO_POLL_TIMEOUT_EN path only when that macro is defined.
module tb_io_poll_master;

    logic        clk;
    logic        reset;
    logic        run;
    logic        pRead;
    logic        pWrite;
    logic [1:0]  addr;
    logic [11:0] pWriteData;
    logic [31:0] pReadData;
    logic [11:0] result;
    logic        done;
    logic [7:0]  txn_count;
    logic        busy;
    logic        err;

    logic [1:0]  status;
    logic [7:0]  sw_lo;
    logic [7:0]  sw_hi;

    int unsigned n_checks;
    int unsigned n_fail;

    io_poll_master #(.POLL_LIMIT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .pRead      (pRead),
        .pWrite     (pWrite),
        .addr       (addr),
        .pWriteData (pWriteData),
        .pReadData  (pReadData),
        .result     (result),
        .done       (done),
        .txn_count  (txn_count),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upper read-data bits carry junk so byte extraction is exercised.
    always_comb begin
        pReadData = 32'hDEAD_BEEF;
        case (addr)
            2'b00:   pReadData = {30'h2A5A_5A5A, status};
            2'b10:   pReadData = {24'hA5A5A5, sw_lo};
            2'b11:   pReadData = {24'h5A5A5A, sw_hi};
            default: pReadData = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_strobes"}, {30'd0, pRead, pWrite}, 32'd0);
        check_val({tag, "_addr"}, 32'(addr), 32'd0);
        check_val({tag, "_wdata"}, 32'(pWriteData), 32'd0);
        check_val({tag, "_result"}, 32'(result), 32'd0);
        check_val({tag, "_txn"}, 32'(txn_count), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int unsigned pulses;
        n_checks = 0;
        n_fail   = 0;
        reset  = 1'b1;
        run    = 1'b0;
        status = 2'b00;
        sw_lo  = 8'h00;
        sw_hi  = 8'h00;
        repeat (3) tick();
        check_reset_outputs("rst");

        // First transaction: 0x12 + 0x34
        reset  = 1'b0;
        run    = 1'b1;
        status = 2'b10;
        sw_lo  = 8'h12;
        sw_hi  = 8'h34;
        tick();
        check_val("pollin_rd", {28'd0, pRead, pWrite, addr}, 32'b1000);
        check_val("pollin_busy", 32'(busy), 32'd1);
        tick();
        check_val("rdlo", {28'd0, pRead, pWrite, addr}, 32'b1010);
        tick();
        check_val("rdhi", {28'd0, pRead, pWrite, addr}, 32'b1011);
        tick();
        check_val("wr_strobe", {28'd0, pRead, pWrite, addr}, 32'b0101);
        check_val("wr_data_046", 32'(pWriteData), 32'h046);
        tick();
        check_val("pollout", {28'd0, pRead, pWrite, addr}, 32'b1000);
        check_val("result_046", 32'(result), 32'h046);
        check_val("pollout_wdata0", 32'(pWriteData), 32'd0);
        status = 2'b01;
        tick();
        check_val("done1_pulse", 32'(done), 32'd1);
        check_val("done1_nostrobe", {30'd0, pRead, pWrite}, 32'd0);
        check_val("done1_txn_old", 32'(txn_count), 32'd0);
        status = 2'b00;
        tick();
        check_val("txn_1", 32'(txn_count), 32'd1);
        check_val("done_cleared", 32'(done), 32'd0);

        // Input never ready: POLL_IN for 50 cycles
        for (int i = 0; i < 50; i++) begin
            check_val("pollin_hold", {27'd0, busy, pRead, pWrite, addr}, 32'b11000);
            if (i < 49) tick();
        end

        // Max operands, output consumed late
        sw_lo  = 8'hFF;
        sw_hi  = 8'hFF;
        status = 2'b10;
        tick();
        status = 2'b00;
        tick();
        tick();
        check_val("wr_data_1fe", 32'(pWriteData), 32'h1FE);
        tick();
        for (int i = 0; i < 20; i++) begin
            check_val("pollout_hold", {27'd0, done, pRead, pWrite, addr}, 32'b01000);
            if (i < 19) tick();
        end
        check_val("result_1fe", 32'(result), 32'h1FE);
        status = 2'b01;
        tick();
        check_val("done2_pulse", 32'(done), 32'd1);
        status = 2'b10;
        sw_lo  = 8'h01;
        sw_hi  = 8'h02;
        tick();
        check_val("txn_2", 32'(txn_count), 32'd2);

        // run dropped in RD_HI: transaction still completes, then IDLE
        tick();
        tick();
        check_val("rdhi_again", 32'(addr), 32'b11);
        run    = 1'b0;
        status = 2'b11;
        tick();
        check_val("wr_after_drop", 32'(pWriteData), 32'h003);
        tick();
        check_val("pollout_after_drop", 32'(pRead), 32'd1);
        tick();
        check_val("done_after_drop", 32'(done), 32'd1);
        tick();
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("txn_3", 32'(txn_count), 32'd3);
        tick();
        check_val("idle_stays", {27'd0, busy, pRead, pWrite, addr}, 32'd0);

        // Back-to-back transactions until the counter wraps
        run    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3000 && pulses < 253; i++) begin
            tick();
            if (done) pulses++;
        end
        check_val("wrap_pulses", pulses, 32'd253);
        check_val("txn_255", 32'(txn_count), 32'd255);
        tick();
        check_val("txn_wrap_0", 32'(txn_count), 32'd0);
        check_val("direct_pollin", 32'(pRead), 32'd1);

        // Reset while in WR
        for (int i = 0; i < 20 && !pWrite; i++) tick();
        check_val("wr_reached", 32'(pWrite), 32'd1);
        check_val("result_pre_rst", 32'(result), 32'h003);
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_wr");
        reset = 1'b0;
        run   = 1'b0;
        tick();
        check_val("post_rst_idle", 32'(busy), 32'd0);

`ifdef IO_POLL_TIMEOUT_EN
        status = 2'b00;
        run    = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) tick();
        check_val("to_last_poll", {28'd0, err, pRead, busy, 1'b0}, 32'b0110);
        tick();
        check_val("to_err", {28'd0, err, pRead, busy, pWrite}, 32'b1010);
        check_val("to_txn_kept", 32'(txn_count), 32'd0);
        tick();
        check_val("err_holds", 32'(err), 32'd1);
        run = 1'b0;
        tick();
        check_val("err_exit", {30'd0, err, busy}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_poll_master.md
IO_POLL_MASTER -- requirements
Module: io_poll_master

Interface
REQ-001 Parameter: POLL_LIMIT, 1000, max cycles spent in one poll state before timeout (used only with IO_POLL_TIMEOUT_EN).
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  level enable; a high level starts transactions and lets them repeat.
REQ-005 pRead  output  1  port read strobe.
REQ-006 pWrite  output  1  port write strobe.
REQ-007 addr  output  2  port address: 00 status, 01 output (LED), 10 input low byte, 11 input high byte.
REQ-008 pWriteData  output  12  write data, valid only while pWrite=1.
REQ-009 pReadData  input  32  read data, combinational from the port in the same cycle as pRead; status bit1 = input ready, bit0 = output consumed.
REQ-010 result  output  12  last sum written to the output port.
REQ-011 done  output  1  one-cycle pulse per completed transaction.
REQ-012 txn_count  output  8  completed-transaction counter.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  poll-timeout flag; tied 0 without IO_POLL_TIMEOUT_EN.

Function
REQ-015 States: IDLE, POLL_IN, RD_LO, RD_HI, WR, POLL_OUT, DONE, plus ERR with IO_POLL_TIMEOUT_EN; one state per cycle except the poll states.
REQ-016 IDLE: pRead=0, pWrite=0, addr=00; run=1 -> POLL_IN.
REQ-017 POLL_IN: pRead=1, addr=00 every cycle; pReadData[1]=1 -> RD_LO, else stay.
REQ-018 RD_LO: pRead=1, addr=10; lo <= pReadData[7:0] at cycle end; -> RD_HI.
REQ-019 RD_HI: pRead=1, addr=11; hi <= pReadData[7:0]; -> WR.
REQ-020 WR: pWrite=1, addr=01, pWriteData = zero-extended 9-bit lo+hi (range 0..510, no overflow); result <= same value; -> POLL_OUT.
REQ-021 POLL_OUT: pRead=1, addr=00; pReadData[0]=1 -> DONE, else stay.
REQ-022 DONE: done=1 for this cycle only; txn_count increments mod 256 (255 -> 0); run=1 -> POLL_IN, run=0 -> IDLE.
REQ-023 pRead and pWrite are never high in the same cycle; pRead=0 and pWrite=0 in IDLE, DONE, ERR.
REQ-024 Deasserting run mid-transaction does not abort: the transaction completes through DONE, then IDLE.
REQ-025 When input ready remains 1, the next transaction proceeds straight through POLL_IN in one cycle and re-reads the current input bytes.
REQ-026 All pRead/pWrite/addr/pWriteData/done/busy outputs are registered decodes of the state register (Moore); pReadData is sampled only in POLL_IN, RD_LO, RD_HI, POLL_OUT.

Reset
REQ-027 On reset: state=IDLE, lo=hi=0, result=0, txn_count=0, done=0, busy=0, err=0, pRead=0, pWrite=0, addr=00, pWriteData=0.
REQ-028 Reset asserted in any state, including mid-poll or WR, takes effect on the next rising edge and overrides run.

Configuration
REQ-029 Macro IO_POLL_TIMEOUT_EN defined: 16-bit poll counter cleared on entry to POLL_IN/POLL_OUT and incremented every poll cycle without the awaited bit; the cycle it equals POLL_LIMIT-1 with the bit still 0 -> ERR.
REQ-030 In ERR: err=1, busy=1, no strobes; exit to IDLE (err cleared) only when run=0; txn_count and result unchanged.
REQ-031 Macro undefined: no counter, no ERR state, err tied 0, poll states wait indefinitely.

Verification
REQ-032 Reset, run=1, status=10b, switches lo=8'h12 hi=8'h34 -> POLL_IN 1 cycle, RD_LO, RD_HI, WR with pWriteData=12'h046, result=12'h046.
REQ-033 lo=8'hFF, hi=8'hFF -> pWriteData=12'h1FE; status bit0 held 0 for 20 cycles -> POLL_OUT held 20 cycles, then bit0=1 -> done pulse, txn_count=1.
REQ-034 Status held 00b with run=1 for 50 cycles -> stays in POLL_IN, pRead=1 addr=00 all 50 cycles, no pWrite.
REQ-035 run dropped during RD_HI -> WR, POLL_OUT, DONE complete, then IDLE; run held with status=11b for 256 transactions -> txn_count wraps to 0.
REQ-036 Reset asserted during WR -> next cycle all outputs at reset values, state IDLE.
REQ-037 With IO_POLL_TIMEOUT_EN, POLL_LIMIT=8, status=00b -> ERR after 8 POLL_IN cycles, err=1; run=0 -> IDLE, err=0.
